// File: rtl/audio_clk_pkg.sv
// Shared audio clocking definitions: recovery FSM states, divider ratios and
// small arithmetic helpers used by the clock blocks.
package audio_clk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_TRACK   = 2'd2,
    ST_LOCKED  = 2'd3
  } recover_state_t;

  localparam int CLKDIV_MCLK_PER_LRCLK = 256;
  localparam int CLKDIV_BCLK_PER_LRCLK = 64;
  localparam int CLKDIV_MCLK_PER_BCLK  = CLKDIV_MCLK_PER_LRCLK / CLKDIV_BCLK_PER_LRCLK;

  function automatic int unsigned abs_diff(input int unsigned a, input int unsigned b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Single-bit flop-chain synchronizer for an asynchronous input.
// Latency STAGES clk cycles; chain clears to 0 on synchronous reset.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], d};
    end
  end

  assign q = r_chain[STAGES-1];

endmodule

// File: rtl/clock_recover.sv
// Recovers edges, period and lock status of an asynchronous external clock.
// Edge strobes lag the sampling edge by SYNC_STAGES+1 clocks; period/locked follow one cycle later.
module clock_recover
  import audio_clk_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int log2maxperiod = 8,
  parameter int LOCK_COUNT    = 4,
  parameter int TOLERANCE     = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ext_clk,
  output logic                     rising_edge,
  output logic                     falling_edge,
  output logic [log2maxperiod-1:0] period,
  output logic                     locked,
  output logic                     timeout
);

  localparam int W  = log2maxperiod;
  localparam int MW = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam logic [W-1:0]  CNT_MAX  = {W{1'b1}};
  localparam logic [W-1:0]  CNT_LAST = CNT_MAX - 1'b1;
  localparam logic [MW-1:0] LOCK_N   = MW'(LOCK_COUNT);

  logic           w_sync;
  logic           w_sat;
  logic           w_match;
  logic [W-1:0]   w_meas;
  logic           r_sync_d;
  logic [W-1:0]   r_cnt;
  logic [W-1:0]   r_ref;
  logic [MW-1:0]  r_match;
  recover_state_t r_state;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (ext_clk),
    .q   (w_sync)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync_d     <= 1'b0;
      rising_edge  <= 1'b0;
      falling_edge <= 1'b0;
    end else begin
      r_sync_d     <= w_sync;
      rising_edge  <= w_sync & ~r_sync_d;
      falling_edge <= ~w_sync & r_sync_d;
    end
  end

  // The counter hits its ceiling on this edge: an arriving edge is clamped to
  // the maximum period and never counts as a match, otherwise it is a timeout.
  assign w_sat   = (r_cnt >= CNT_LAST);
  assign w_meas  = w_sat ? CNT_MAX : r_cnt;
  assign w_match = !w_sat &&
                   (abs_diff(32'(r_cnt), 32'(r_ref)) <= $unsigned(TOLERANCE));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_ref   <= '0;
      r_match <= '0;
      r_state <= ST_IDLE;
      period  <= '0;
      locked  <= 1'b0;
      timeout <= 1'b0;
    end else begin
      timeout <= 1'b0;

      if (rising_edge) begin
        r_cnt <= W'(1);
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (rising_edge) begin
            r_state <= ST_MEASURE;
          end
        end

        ST_MEASURE: begin
          if (rising_edge) begin
            period  <= w_meas;
            r_ref   <= w_meas;
            r_match <= '0;
            r_state <= ST_TRACK;
          end else if (w_sat) begin
            timeout <= 1'b1;
            r_state <= ST_IDLE;
          end
        end

        // r_ref is the anchor period; it only moves on a mismatch so small
        // jitter around it does not drift the lock reference.
        ST_TRACK: begin
          if (rising_edge) begin
            period <= w_meas;
            if (w_match) begin
              if (r_match + 1'b1 >= LOCK_N) begin
                r_match <= LOCK_N;
                r_state <= ST_LOCKED;
                locked  <= 1'b1;
              end else begin
                r_match <= r_match + 1'b1;
              end
            end else begin
              r_match <= '0;
              r_ref   <= w_meas;
            end
          end else if (w_sat) begin
            timeout <= 1'b1;
            r_match <= '0;
            r_state <= ST_IDLE;
          end
        end

        ST_LOCKED: begin
          if (rising_edge) begin
            period <= w_meas;
            if (!w_match) begin
              r_match <= '0;
              r_ref   <= w_meas;
              r_state <= ST_TRACK;
              locked  <= 1'b0;
            end
          end else if (w_sat) begin
            timeout <= 1'b1;
            r_match <= '0;
            r_state <= ST_IDLE;
            locked  <= 1'b0;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          locked  <= 1'b0;
        end
      endcase
    end
  end

endmodule
